sdr_16_rd_capture: RTL and testbench



---
 rtl/sdr_16_rd_capture_if.sv | 26 ++
 rtl/sdr_16_rd_capture.sv | 162 ++++++++++++++++
 tb/tb_sdr_16_rd_capture.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdr_16_rd_capture_if.sv
// Read-capture bus between the SDRAM controller side and the ingress FIFO.
// master: controller/FIFO side; slave: the capture stage.
interface sdr_16_rd_capture_if #(
    parameter int PEND_W = 3
);
    logic              cmd_read;
    logic [15:0]       dq_i;
    logic              fifo_full;
    logic              ovf_clr;
    logic              fifo_wr;
    logic [31:0]       fifo_dat;
    logic              rd_pending;
    logic [PEND_W-1:0] pend_cnt;
    logic              proto_err;
    logic              overflow;

    modport master (
        output cmd_read, dq_i, fifo_full, ovf_clr,
        input  fifo_wr, fifo_dat, rd_pending, pend_cnt, proto_err, overflow
    );

    modport slave (
        input  cmd_read, dq_i, fifo_full, ovf_clr,
        output fifo_wr, fifo_dat, rd_pending, pend_cnt, proto_err, overflow
    );
endinterface

// File: rtl/sdr_16_rd_capture.sv
// SDR SDRAM read-data capture: tracks reads through CAS latency, captures the
// two 16-bit beats from DQ and writes them as one 32-bit word to the ingress FIFO.
// Optional macro SDR_RD_OVERFLOW_EN: honour fifo_full by dropping the word and
// raising a sticky overflow flag; when undefined, fifo_full is ignored.
module sdr_16_rd_capture #(
    parameter int CL     = 2,
    parameter int IO_DLY = 1,
    parameter int PEND_W = 3
) (
    input logic               sdram_clk,
    input logic               sdram_rst,
    sdr_16_rd_capture_if.slave bus
);
    localparam int                MK_LEN   = CL + IO_DLY;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_LO,
        CAP_WR
    } cap_state_t;

    cap_state_t               state_q, state_d;
    logic [IO_DLY-1:0][15:0]  dq_p;
    logic [15:0]              dq_r;
    logic [MK_LEN-1:0]        vld_p;
    logic                     marker;
    logic                     cmd_prev;
    logic                     accept;
    logic [15:0]              hi;
    logic [31:0]              dat_q;
    logic [PEND_W-1:0]        pend_q;
    logic                     perr_q;
    logic                     hi_ld;
    logic                     dat_ld;
    logic                     done;
    logic                     drop;
    logic                     wr_en;

    // Saturating in-flight counter update; simultaneous inc and dec cancel.
    function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                    input logic inc, input logic dec);
        if (inc && !dec) return (cnt == PEND_MAX) ? cnt : cnt + PEND_W'(1);
        if (dec && !inc) return (cnt == '0) ? cnt : cnt - PEND_W'(1);
        return cnt;
    endfunction

    // A pulse directly following another is a protocol error and is not tracked.
    assign accept = bus.cmd_read & ~cmd_prev;
    assign dq_r   = dq_p[IO_DLY-1];
    assign marker = vld_p[MK_LEN-1];

    // Input register chain from the DQ pins.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            dq_p <= '0;
        end else begin
            dq_p[0] <= bus.dq_i;
            for (int i = IO_DLY - 1; i > 0; i--) dq_p[i] <= dq_p[i-1];
        end
    end

    // Read marker delay line; its last tap lines up with beat0 on dq_r.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            vld_p    <= '0;
            cmd_prev <= 1'b0;
        end else begin
            vld_p    <= {vld_p[MK_LEN-2:0], accept};
            cmd_prev <= bus.cmd_read;
        end
    end

    // Capture sequencer state register.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) state_q <= CAP_IDLE;
        else           state_q <= state_d;
    end

    // Sequencer next state and beat-load strobes.
    always_comb begin
        state_d = state_q;
        hi_ld   = 1'b0;
        dat_ld  = 1'b0;
        done    = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (marker) begin
                    hi_ld   = 1'b1;
                    state_d = CAP_LO;
                end
            end
            CAP_LO: begin
                dat_ld  = 1'b1;
                state_d = CAP_WR;
            end
            CAP_WR: begin
                done = 1'b1;
                if (marker) begin
                    hi_ld   = 1'b1;
                    state_d = CAP_LO;
                end else begin
                    state_d = CAP_IDLE;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    // Beat capture: the low beat goes straight into the output word so that
    // fifo_dat is valid in the CAP_WR cycle and holds between writes.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            hi    <= '0;
            dat_q <= '0;
        end else begin
            if (hi_ld)  hi    <= dq_r;
            if (dat_ld) dat_q <= {hi, dq_r};
        end
    end

    // Words in flight: counts accepted reads until their CAP_WR cycle.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) pend_q <= '0;
        else           pend_q <= pend_next(pend_q, accept, done);
    end

    // Sticky protocol-error flag; clear wins over a new set.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst)             perr_q <= 1'b0;
        else if (bus.ovf_clr)      perr_q <= 1'b0;
        else if (bus.cmd_read && cmd_prev) perr_q <= 1'b1;
    end

`ifdef SDR_RD_OVERFLOW_EN
    logic ovf_q;

    assign drop = done & bus.fifo_full;

    // Sticky overflow flag for dropped words; clear wins over a new set.
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst)        ovf_q <= 1'b0;
        else if (bus.ovf_clr) ovf_q <= 1'b0;
        else if (drop)        ovf_q <= 1'b1;
    end

    assign bus.overflow = ovf_q;
`else
    logic unused_full;

    assign unused_full  = bus.fifo_full;
    assign drop         = 1'b0;
    assign bus.overflow = 1'b0;
`endif

    assign wr_en          = done & ~drop;
    assign bus.fifo_wr    = wr_en;
    assign bus.fifo_dat   = dat_q;
    assign bus.pend_cnt   = pend_q;
    assign bus.rd_pending = (pend_q != '0);
    assign bus.proto_err  = perr_q;
endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Directed bench for sdr_16_rd_capture: table-driven single/back-to-back reads
// on a CL=2/IO_DLY=1 instance, plus hand-written sequences for protocol error,
// FIFO-full, reset mid-burst and a CL=3/IO_DLY=2 instance.
`timescale 1ns/1ps
module tb_sdr_16_rd_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sdr_16_rd_capture_if #(.PEND_W(3)) bus  ();
    sdr_16_rd_capture_if #(.PEND_W(3)) bus3 ();

    sdr_16_rd_capture #(.CL(2), .IO_DLY(1), .PEND_W(3)) dut (
        .sdram_clk (clk),
        .sdram_rst (rst),
        .bus       (bus)
    );

    sdr_16_rd_capture #(.CL(3), .IO_DLY(2), .PEND_W(3)) dut3 (
        .sdram_clk (clk),
        .sdram_rst (rst),
        .bus       (bus3)
    );

    typedef struct {
        logic        cmd;
        logic [15:0] dq;
        logic        full;
        logic        wr;
        logic [31:0] dat;
        logic [2:0]  pend;
    } vec_t;

    vec_t tbl [32];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.cmd_read   = 1'b0;
        bus.dq_i       = 16'h0000;
        bus.fifo_full  = 1'b0;
        bus.ovf_clr    = 1'b0;
        bus3.cmd_read  = 1'b0;
        bus3.dq_i      = 16'h0000;
        bus3.fifo_full = 1'b0;
        bus3.ovf_clr   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rst_fifo_wr",    {31'd0, bus.fifo_wr},    32'd0);
        chk("rst_fifo_dat",   bus.fifo_dat,            32'd0);
        chk("rst_rd_pending", {31'd0, bus.rd_pending}, 32'd0);
        chk("rst_pend_cnt",   {29'd0, bus.pend_cnt},   32'd0);
        chk("rst_proto_err",  {31'd0, bus.proto_err},  32'd0);
        chk("rst_overflow",   {31'd0, bus.overflow},   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 32; i++)
            tbl[i] = '{cmd: 1'b0, dq: 16'hFFFF, full: 1'b0, wr: 1'b0, dat: 32'd0, pend: 3'd0};
    endtask

    // Expected pend = reads issued before the cycle minus words written before it;
    // expected fifo_dat holds the last written word.
    task automatic fill_expect(input int n);
        int          run;
        logic [31:0] held;
        run  = 0;
        held = 32'd0;
        for (int i = 0; i < n; i++) begin
            tbl[i].pend = 3'(run);
            if (tbl[i].wr) held = tbl[i].dat;
            tbl[i].dat = held;
            run = run + int'(tbl[i].cmd) - int'(tbl[i].wr);
        end
    endtask

    task automatic run_table(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.cmd_read  = tbl[i].cmd;
            bus.dq_i      = tbl[i].dq;
            bus.fifo_full = tbl[i].full;
            @(negedge clk);
            chk($sformatf("%s_wr_c%0d", tag, i),   {31'd0, bus.fifo_wr},    {31'd0, tbl[i].wr});
            chk($sformatf("%s_dat_c%0d", tag, i),  bus.fifo_dat,            tbl[i].dat);
            chk($sformatf("%s_pend_c%0d", tag, i), {29'd0, bus.pend_cnt},   {29'd0, tbl[i].pend});
            chk($sformatf("%s_rdp_c%0d", tag, i),  {31'd0, bus.rd_pending}, {31'd0, (tbl[i].pend != 3'd0)});
        end
        idle_inputs();
    endtask

    initial begin
        int wr_cnt;
        int exp_wr;
        idle_inputs();

        // Single read.
        do_reset();
        clear_tbl();
        tbl[10].cmd = 1'b1;
        tbl[12].dq  = 16'hA5A5;
        tbl[13].dq  = 16'h3C3C;
        tbl[15].wr  = 1'b1;
        tbl[15].dat = 32'hA5A53C3C;
        fill_expect(20);
        run_table("single", 20);

        // Back-to-back reads at maximum rate.
        do_reset();
        clear_tbl();
        for (int k = 0; k < 4; k++) begin
            tbl[10 + 2*k].cmd = 1'b1;
            tbl[15 + 2*k].wr  = 1'b1;
        end
        for (int k = 0; k < 8; k++) tbl[12 + k].dq = 16'(k + 1);
        tbl[15].dat = 32'h00010002;
        tbl[17].dat = 32'h00030004;
        tbl[19].dat = 32'h00050006;
        tbl[21].dat = 32'h00070008;
        fill_expect(24);
        run_table("b2b", 24);

        // Protocol error: pulses in consecutive cycles.
        do_reset();
        wr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.cmd_read = (c == 5 || c == 6);
            bus.dq_i     = (c == 7) ? 16'h1111 : (c == 8) ? 16'h2222 : 16'hEEEE;
            @(negedge clk);
            if (bus.fifo_wr) wr_cnt++;
            if (c == 6) chk("perr_before", {31'd0, bus.proto_err}, 32'd0);
            if (c == 7) chk("perr_set",    {31'd0, bus.proto_err}, 32'd1);
            if (c == 7) chk("perr_pend",   {29'd0, bus.pend_cnt},  32'd1);
        end
        chk("perr_wr_count", 32'(wr_cnt), 32'd1);
        chk("perr_word",     bus.fifo_dat, 32'h11112222);
        @(posedge clk); #1;
        idle_inputs();
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        chk("perr_cleared", {31'd0, bus.proto_err}, 32'd0);

        // FIFO full during the write cycle of the 2nd of 3 reads.
        do_reset();
        wr_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            bus.cmd_read  = (c == 10 || c == 12 || c == 14);
            bus.dq_i      = (c >= 12 && c <= 17) ? 16'(c - 11) : 16'hEEEE;
            bus.fifo_full = (c == 17);
            @(negedge clk);
            if (bus.fifo_wr) wr_cnt++;
        end
        idle_inputs();
`ifdef SDR_RD_OVERFLOW_EN
        exp_wr = 2;
`else
        exp_wr = 3;
`endif
        chk("ovf_wr_count", 32'(wr_cnt), 32'(exp_wr));
        chk("ovf_flag",     {31'd0, bus.overflow}, (exp_wr == 2) ? 32'd1 : 32'd0);
        chk("ovf_pend",     {29'd0, bus.pend_cnt}, 32'd0);
        chk("ovf_last_word", bus.fifo_dat, 32'h00050006);
        @(posedge clk); #1;
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

        // CL=3, IO_DLY=2 instance: beats from pins in cycles 3 and 4.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            bus3.cmd_read = (c == 0);
            bus3.dq_i     = (c == 3) ? 16'hBEEF : (c == 4) ? 16'hCAFE : 16'(16'h1000 + c);
            @(negedge clk);
            chk($sformatf("cl3_wr_c%0d", c), {31'd0, bus3.fifo_wr}, (c == 7) ? 32'd1 : 32'd0);
            if (c == 7) chk("cl3_dat", bus3.fifo_dat, 32'hBEEFCAFE);
            if (c == 1) chk("cl3_pend_c1", {29'd0, bus3.pend_cnt}, 32'd1);
            if (c == 8) chk("cl3_pend_c8", {29'd0, bus3.pend_cnt}, 32'd0);
        end
        idle_inputs();

        // Reset pulsed one cycle after a read.
        do_reset();
        wr_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            bus.cmd_read = (c == 10);
            bus.dq_i     = (c == 12) ? 16'h5555 : (c == 13) ? 16'h6666 : 16'h0000;
            if (c == 11) begin
                chk("rstmid_pend_before", {29'd0, bus.pend_cnt}, 32'd1);
                rst = 1'b1;
                #1;
                chk("rstmid_pend_now", {29'd0, bus.pend_cnt},   32'd0);
                chk("rstmid_rdp_now",  {31'd0, bus.rd_pending}, 32'd0);
            end
            if (c == 12) rst = 1'b0;
            @(negedge clk);
            if (bus.fifo_wr) wr_cnt++;
        end
        idle_inputs();
        chk("rstmid_wr_count", 32'(wr_cnt), 32'd0);
        chk("rstmid_pend_end", {29'd0, bus.pend_cnt}, 32'd0);
        chk("rstmid_dat",      bus.fifo_dat, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
